uart_rx_frame_receiver: RTL and testbench

- UART receive counterpart of the TX serializer. Oversamples RX_IN at CLK rate by PRESCALE, detects the start bit and majority-votes each bit at mid-bit.
- Deserializes DATA_WIDTH bits LSB first, with optional even/odd parity, then checks the stop bit.
- Presents the parallel word with a one-cycle DATA_VALID pulse, plus parity and stop error flags, to the RX-side sync/register logic of the multi-clock system.

---
 rtl/uart_rx_frame_receiver.sv | 165 ++++++++++++++++
 tb/tb_uart_rx_frame_receiver.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_receiver.sv
// UART frame receiver: oversamples RX_IN by PRESCALE and majority-votes three mid-bit samples.
// Deserializes LSB-first data with optional parity, checks the stop bit and pulses DATA_VALID on a clean frame.
module uart_rx_frame_receiver #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  output logic [DATA_WIDTH-1:0]     P_DATA,
  output logic                      DATA_VALID,
  output logic                      PAR_ERR,
  output logic                      STP_ERR
);

  // state  | meaning
  // IDLE   | line idle, waiting for a low level
  // START  | validating the start bit (glitch rejection)
  // DATA   | shifting in DATA_WIDTH payload bits
  // PARITY | sampling the parity bit
  // STOP   | sampling the stop bit, publishing the result
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  localparam int IW = $clog2(DATA_WIDTH);
  localparam int BW = IW + 1;
  localparam logic [PRESCALE_WIDTH-1:0] ONE_E    = PRESCALE_WIDTH'(1);
  localparam logic [BW-1:0]             ONE_B    = BW'(1);
  localparam logic [BW-1:0]             LAST_BIT = BW'(DATA_WIDTH - 1);

  state_t                    state_q, state_d;
  logic [PRESCALE_WIDTH-1:0] edge_q, edge_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [DATA_WIDTH-1:0]     shift_q, shift_d;
  logic [2:0]                samp_q, samp_d;
  logic                      par_en_q, par_en_d;
  logic                      par_typ_q, par_typ_d;
  logic                      par_pend_q, par_pend_d;
  logic [DATA_WIDTH-1:0]     p_data_q, p_data_d;
  logic                      valid_q, valid_d;
  logic                      par_err_q, par_err_d;
  logic                      stp_err_q, stp_err_d;

  logic [PRESCALE_WIDTH-1:0] last_edge, mid_edge, pre_mid, post_mid;
  logic                      bit_end, voted;

  assign mid_edge  = PRESCALE >> 1;
  assign last_edge = PRESCALE - ONE_E;
  assign pre_mid   = mid_edge - ONE_E;
  assign post_mid  = mid_edge + ONE_E;
  assign bit_end   = (edge_q == last_edge);
  assign voted     = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    samp_d     = samp_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_pend_d = par_pend_q;
    p_data_d   = p_data_q;
    valid_d    = 1'b0;
    par_err_d  = par_err_q;
    stp_err_d  = stp_err_q;

    if (state_q != IDLE) begin
      edge_d = bit_end ? '0 : edge_q + ONE_E;
      if (edge_q == pre_mid)  samp_d[0] = RX_IN;
      if (edge_q == mid_edge) samp_d[1] = RX_IN;
      if (edge_q == post_mid) samp_d[2] = RX_IN;
    end

    case (state_q)
      IDLE: begin
        edge_d = '0;
        bit_d  = '0;
        // The detecting cycle itself is edge 0 of the start bit.
        if (!RX_IN) begin
          state_d    = START;
          edge_d     = ONE_E;
          par_err_d  = 1'b0;
          stp_err_d  = 1'b0;
          par_pend_d = 1'b0;
        end
      end
      START: begin
        if (bit_end) begin
          if (voted) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_d     = '0;
            par_en_d  = PAR_EN;
            par_typ_d = PAR_TYP;
          end
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d[bit_q[IW-1:0]] = voted;
          bit_d = bit_q + ONE_B;
          if (bit_q == LAST_BIT) state_d = par_en_q ? PARITY : STOP;
        end
      end
      PARITY: begin
        if (bit_end) begin
          par_pend_d = voted ^ (^shift_q) ^ par_typ_q;
          state_d    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          state_d   = IDLE;
          stp_err_d = ~voted;
          par_err_d = par_pend_q;
          if (voted && !par_pend_q) begin
            p_data_d = shift_q;
            valid_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      edge_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      samp_q     <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_pend_q <= 1'b0;
      p_data_q   <= '0;
      valid_q    <= 1'b0;
      par_err_q  <= 1'b0;
      stp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      samp_q     <= samp_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_pend_q <= par_pend_d;
      p_data_q   <= p_data_d;
      valid_q    <= valid_d;
      par_err_q  <= par_err_d;
      stp_err_q  <= stp_err_d;
    end
  end

  assign P_DATA     = p_data_q;
  assign DATA_VALID = valid_q;
  assign PAR_ERR    = par_err_q;
  assign STP_ERR    = stp_err_q;

endmodule

// File: tb/tb_uart_rx_frame_receiver.sv
// Bench for uart_rx_frame_receiver: drives serial frames slot by slot and compares
// against a frame-level model (payload, parity rule, stop level, latency N*PRESCALE).
module tb_uart_rx_frame_receiver;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic [5:0] PRESCALE;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_ERR;
  logic       STP_ERR;

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         vq_cyc[$];
  logic [7:0] vq_data[$];
  logic [7:0] last_good = 8'h00;

  uart_rx_frame_receiver #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PRESCALE(PRESCALE), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .PAR_ERR(PAR_ERR),
    .STP_ERR(STP_ERR)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  always @(negedge CLK) begin
    if (DATA_VALID === 1'b1) begin
      vq_cyc.push_back(cyc);
      vq_data.push_back(P_DATA);
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  // Frame-level expectation: {valid, par_err, stp_err}
  function automatic logic [2:0] model(input logic [7:0] d, input logic pen, input logic ptyp,
                                       input logic pbit, input logic stopb);
    logic perr, serr;
    perr = pen && (pbit != ((^d) ^ ptyp));
    serr = !stopb;
    return {!perr && !serr, perr, serr};
  endfunction

  task automatic idle(input int n);
    RX_IN = 1'b1;
    repeat (n) begin
      @(posedge CLK); #1;
    end
  endtask

  // Drives one whole frame, one slot per clock; gbit >= 0 inverts the mid sample of that data bit.
  task automatic send_frame(input logic [7:0] data, input int p, input logic pen, input logic ptyp,
                            input logic pbit, input logic stopb, input int gbit, input logic scramble);
    logic [10:0] bits;
    int          nbits;
    logic        lvl;
    nbits    = pen ? 11 : 10;
    bits     = 11'h7FF;
    bits[0]  = 1'b0;
    bits[8:1] = data;
    if (pen) begin
      bits[9]  = pbit;
      bits[10] = stopb;
    end else begin
      bits[9]  = stopb;
    end
    PRESCALE = 6'(p);
    PAR_EN   = pen;
    PAR_TYP  = ptyp;
    for (int s = 0; s < nbits * p; s++) begin
      lvl = bits[s / p];
      if (gbit >= 0 && s == (1 + gbit) * p + p / 2) lvl = ~lvl;
      if (scramble && s == p + 1) begin
        PAR_EN  = 1'($urandom_range(1, 0));
        PAR_TYP = 1'($urandom_range(1, 0));
      end
      RX_IN = lvl;
      @(posedge CLK); #1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; RX_IN = 1'b1; PRESCALE = 6'd8; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", DATA_VALID); end
    checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL reset_pdata got %h want 00", P_DATA); end
    checks++; if (PAR_ERR !== 1'b0) begin errors++; $display("FAIL reset_parerr got %b want 0", PAR_ERR); end
    checks++; if (STP_ERR !== 1'b0) begin errors++; $display("FAIL reset_stperr got %b want 0", STP_ERR); end
    RST = 1'b0;
    idle(4);
  endtask

  task automatic test_start_glitch();
    int s0;
    vq_cyc.delete(); vq_data.delete();
    PRESCALE = 6'd8;
    RX_IN = 1'b0;
    repeat (2) begin @(posedge CLK); #1; end
    idle(12);
    checks++; if (vq_cyc.size() != 0) begin errors++; $display("FAIL glitch_novalid got %0d pulses want 0", vq_cyc.size()); end
    checks++; if ({P_DATA, PAR_ERR, STP_ERR} !== 10'h0) begin errors++; $display("FAIL glitch_outputs got %h/%b/%b want 00/0/0", P_DATA, PAR_ERR, STP_ERR); end
    s0 = cyc;
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(3);
    last_good = 8'h81;
    checks++; if (vq_cyc.size() != 1 || vq_cyc[0] - s0 != 80 || vq_data[0] !== 8'h81) begin
      errors++; $display("FAIL after_glitch_frame got %0d pulses want 1 at +80 data 81", vq_cyc.size()); end
    checks++; if (P_DATA !== 8'h81) begin errors++; $display("FAIL after_glitch_pdata got %h want 81", P_DATA); end
  endtask

  task automatic test_basic();
    int s0;
    vq_cyc.delete(); vq_data.delete();
    s0 = cyc;
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(3);
    last_good = 8'hA5;
    checks++; if (vq_cyc.size() != 1) begin errors++; $display("FAIL basic_pulses got %0d want 1", vq_cyc.size()); end
    else begin
      checks++; if (vq_cyc[0] - s0 != 80) begin errors++; $display("FAIL basic_latency got %0d want 80", vq_cyc[0] - s0); end
      checks++; if (vq_data[0] !== 8'hA5) begin errors++; $display("FAIL basic_data got %h want a5", vq_data[0]); end
    end
    checks++; if (PAR_ERR !== 1'b0 || STP_ERR !== 1'b0) begin errors++; $display("FAIL basic_flags got %b%b want 00", PAR_ERR, STP_ERR); end
  endtask

  task automatic test_parity();
    int s0;
    vq_cyc.delete(); vq_data.delete();
    s0 = cyc;
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    idle(3);
    last_good = 8'h3C;
    checks++; if (vq_cyc.size() != 1 || vq_cyc[0] - s0 != 176 || vq_data[0] !== 8'h3C) begin
      errors++; $display("FAIL parity_good got %0d pulses want 1 at +176 data 3c", vq_cyc.size()); end
    checks++; if (PAR_ERR !== 1'b0) begin errors++; $display("FAIL parity_good_flag got %b want 0", PAR_ERR); end
    vq_cyc.delete(); vq_data.delete();
    send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    idle(3);
    checks++; if (PAR_ERR !== 1'b1) begin errors++; $display("FAIL parity_bad_flag got %b want 1", PAR_ERR); end
    checks++; if (vq_cyc.size() != 0) begin errors++; $display("FAIL parity_bad_novalid got %0d want 0", vq_cyc.size()); end
    checks++; if (P_DATA !== last_good) begin errors++; $display("FAIL parity_bad_hold got %h want %h", P_DATA, last_good); end
  endtask

  task automatic test_stop_err();
    int s0;
    vq_cyc.delete(); vq_data.delete();
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    s0 = cyc;
    fork
      send_frame(8'h33, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
      begin
        checks++; if (STP_ERR !== 1'b1) begin errors++; $display("FAIL stop_err_flag got %b want 1", STP_ERR); end
        checks++; if (DATA_VALID !== 1'b0) begin errors++; $display("FAIL stop_err_valid got %b want 0", DATA_VALID); end
        @(posedge CLK); #2;
        checks++; if (STP_ERR !== 1'b0) begin errors++; $display("FAIL stop_err_clear got %b want 0", STP_ERR); end
      end
    join
    idle(3);
    last_good = 8'h33;
    checks++; if (vq_cyc.size() != 1 || vq_cyc[0] - s0 != 80 || vq_data[0] !== 8'h33) begin
      errors++; $display("FAIL break_restart got %0d pulses want 1 at +80 data 33", vq_cyc.size()); end
  endtask

  task automatic test_majority();
    vq_cyc.delete(); vq_data.delete();
    send_frame(8'hFF, 8, 1'b0, 1'b0, 1'b0, 1'b1, 3, 1'b0);
    idle(3);
    last_good = 8'hFF;
    checks++; if (vq_cyc.size() != 1 || vq_data[0] !== 8'hFF) begin
      errors++; $display("FAIL majority got %0d pulses want 1 data ff", vq_cyc.size()); end
    checks++; if (P_DATA !== 8'hFF) begin errors++; $display("FAIL majority_pdata got %h want ff", P_DATA); end
  endtask

  task automatic test_back_to_back();
    int s0;
    vq_cyc.delete(); vq_data.delete();
    s0 = cyc;
    send_frame(8'h12, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    send_frame(8'h34, 8, 1'b0, 1'b0, 1'b0, 1'b1, -1, 1'b0);
    RX_IN = 1'b0;
    repeat (8) begin @(posedge CLK); #1; end
    RX_IN = 1'b1;
    repeat (20) begin @(posedge CLK); #1; end
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    last_good = 8'h00;
    checks++; if ({P_DATA, DATA_VALID, PAR_ERR, STP_ERR} !== 11'h0) begin
      errors++; $display("FAIL b2b_reset_outputs got %h/%b/%b/%b want all 0", P_DATA, DATA_VALID, PAR_ERR, STP_ERR); end
    idle(120);
    checks++; if (vq_cyc.size() != 2) begin errors++; $display("FAIL b2b_pulses got %0d want 2", vq_cyc.size()); end
    else begin
      checks++; if (vq_cyc[0] - s0 != 80 || vq_cyc[1] - vq_cyc[0] != 80) begin
        errors++; $display("FAIL b2b_timing got +%0d,+%0d want +80,+80", vq_cyc[0] - s0, vq_cyc[1] - vq_cyc[0]); end
      checks++; if (vq_data[0] !== 8'h12 || vq_data[1] !== 8'h34) begin
        errors++; $display("FAIL b2b_data got %h,%h want 12,34", vq_data[0], vq_data[1]); end
    end
    checks++; if (P_DATA !== 8'h00) begin errors++; $display("FAIL b2b_abort_pdata got %h want 00", P_DATA); end
  endtask

  task automatic test_random();
    int         s0, p, gbit, nbits;
    logic [7:0] d;
    logic       pen, ptyp, pbit, stopb;
    logic [2:0] exp;
    for (int i = 0; i < 20; i++) begin
      case ($urandom_range(2, 0))
        0: p = 8;
        1: p = 16;
        default: p = 32;
      endcase
      d     = 8'($urandom);
      pen   = 1'($urandom_range(1, 0));
      ptyp  = 1'($urandom_range(1, 0));
      pbit  = ((^d) ^ ptyp) ^ ($urandom_range(3, 0) == 0);
      stopb = ($urandom_range(4, 0) != 0);
      gbit  = int'($urandom_range(8, 0)) - 1;
      nbits = pen ? 11 : 10;
      exp   = model(d, pen, ptyp, pbit, stopb);
      vq_cyc.delete(); vq_data.delete();
      s0 = cyc;
      send_frame(d, p, pen, ptyp, pbit, stopb, gbit, 1'b1);
      idle(3);
      if (exp[2]) last_good = d;
      checks++; if (vq_cyc.size() != (exp[2] ? 1 : 0)) begin
        errors++; $display("FAIL rand%0d_pulses got %0d want %0d", i, vq_cyc.size(), exp[2]); end
      else if (exp[2]) begin
        checks++; if (vq_cyc[0] - s0 != nbits * p || vq_data[0] !== d) begin
          errors++; $display("FAIL rand%0d_frame got +%0d %h want +%0d %h", i, vq_cyc[0] - s0, vq_data[0], nbits * p, d); end
      end
      checks++; if (PAR_ERR !== exp[1] || STP_ERR !== exp[0]) begin
        errors++; $display("FAIL rand%0d_flags got %b%b want %b%b", i, PAR_ERR, STP_ERR, exp[1], exp[0]); end
      checks++; if (P_DATA !== last_good) begin
        errors++; $display("FAIL rand%0d_pdata got %h want %h", i, P_DATA, last_good); end
    end
  endtask

  initial begin
    test_reset();
    test_start_glitch();
    test_basic();
    test_parity();
    test_stop_err();
    test_majority();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
